regif_task_scheduler: RTL and testbench

REGIF_TASK_SCHEDULER -- requirements
Module: regif_task_scheduler

---
 rtl/regif_task_scheduler_if.sv | 41 ++++
 rtl/regif_task_scheduler.sv | 318 +++++++++++++++++++++++++++++++
 tb/tb_regif_task_scheduler.sv | 355 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regif_task_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module      : regif_task_scheduler_if
//  Description : Register-bus bundle for the task scheduler. The master side
//                drives address, write data and the read/write strobes; the
//                slave side returns read data with a one-cycle qualifier.
//  Signals     : regif_addr   [21:0]  register byte address
//                regif_wdata  [31:0]  write data
//                regif_wen            write strobe, one write per high cycle
//                regif_ren            read strobe
//                regif_rdata  [31:0]  read data (0 when rvalid is low)
//                regif_rvalid         read-data qualifier
//  Revision    : 1.0  initial release
// ============================================================================
interface regif_task_scheduler_if;
    logic [21:0] regif_addr;
    logic [31:0] regif_wdata;
    logic        regif_wen;
    logic        regif_ren;
    logic [31:0] regif_rdata;
    logic        regif_rvalid;

    modport master (
        output regif_addr,
        output regif_wdata,
        output regif_wen,
        output regif_ren,
        input  regif_rdata,
        input  regif_rvalid
    );

    modport slave (
        input  regif_addr,
        input  regif_wdata,
        input  regif_wen,
        input  regif_ren,
        output regif_rdata,
        output regif_rvalid
    );
endinterface
`default_nettype wire

// File: rtl/regif_task_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : regif_task_scheduler
//  Description : Register-programmed task scheduler. Unit IDs are queued in an
//                8-entry FIFO through the QUEUE register; once GO is written
//                the scheduler issues one start pulse per entry and waits for
//                the matching completion before issuing the next. A per-task
//                cycle limit (TIMEOUT) moves the scheduler into an error state.
//  Ports       : clk                 clock, rising edge
//                rst                 synchronous active-low reset
//                regif               register bus (slave modport)
//                start_*             one-cycle start pulses, one per unit
//                complete_*          unit-done pulses, one per unit
//                sched_irq           level interrupt: queue drained or error
//  Register map: 0x000000 CTRL    (W)   bit0 GO, bit1 ABORT, bit2 CLR
//                0x000004 QUEUE   (W)   wdata[2:0] = unit ID (7 is illegal)
//                0x000008 STATUS  (R)
//                0x00000C TIMEOUT (R/W) cycle limit, 0 disables
//  Revision    : 1.0  initial release
// ============================================================================
module regif_task_scheduler (
    input  logic                         clk,
    input  logic                         rst,
    regif_task_scheduler_if.slave        regif,
    output logic                         start_mov_ddr2gb,
    output logic                         start_mov_gb2lb,
    output logic                         start_comp_conv,
    output logic                         start_comp_fc,
    output logic                         start_comp_ape,
    output logic                         start_comp_reshape,
    output logic                         start_lpe,
    input  logic                         complete_mov_ddr2gb,
    input  logic                         complete_mov_gb2lb,
    input  logic                         complete_comp_conv,
    input  logic                         complete_comp_fc,
    input  logic                         complete_comp_ape,
    input  logic                         complete_comp_reshape,
    input  logic                         complete_lpe,
    output logic                         sched_irq
);

    localparam logic [21:0] ADDR_CTRL    = 22'h000000;
    localparam logic [21:0] ADDR_QUEUE   = 22'h000004;
    localparam logic [21:0] ADDR_STATUS  = 22'h000008;
    localparam logic [21:0] ADDR_TIMEOUT = 22'h00000C;
    localparam logic [2:0]  BAD_ID       = 3'd7;
    localparam logic [3:0]  FIFO_DEPTH   = 4'd8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_ERR   = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t       state;
    state_t       state_nxt;

    logic [2:0]   fifo_mem [8];
    logic [2:0]   rd_ptr;
    logic [2:0]   wr_ptr;
    logic [3:0]   count;

    logic         run;
    logic         sticky_tmo;
    logic         sticky_ovf;
    logic         sticky_bad;
    logic         irq;
    logic [31:0]  timeout_lim;
    logic [31:0]  tmo_cnt;
    logic [2:0]   cur_id;
    logic [15:0]  done_cnt;
    logic         rvalid_q;
    logic [31:0]  rdata_q;

    // ------------------------------------------------------------------
    // Register decode
    // ------------------------------------------------------------------
    logic         wr_ctrl;
    logic         wr_queue;
    logic         wr_timeout;
    logic         abort;
    logic         go;
    logic         clr;
    logic         push_req;
    logic         push_ok;
    logic         bad_push;
    logic         ovf_set;
    logic         empty;
    logic         full;
    logic [2:0]   head;
    logic [7:0]   complete_vec;

    assign wr_ctrl    = regif.regif_wen && (regif.regif_addr == ADDR_CTRL);
    assign wr_queue   = regif.regif_wen && (regif.regif_addr == ADDR_QUEUE);
    assign wr_timeout = regif.regif_wen && (regif.regif_addr == ADDR_TIMEOUT);

    // ABORT wins over GO when both bits are set in one write.
    assign abort    = wr_ctrl && regif.regif_wdata[1];
    assign go       = wr_ctrl && regif.regif_wdata[0] && !regif.regif_wdata[1];
    assign clr      = wr_ctrl && regif.regif_wdata[2];

    assign push_req = wr_queue && (regif.regif_wdata[2:0] != BAD_ID);
    assign bad_push = wr_queue && (regif.regif_wdata[2:0] == BAD_ID);

    assign empty    = (count == 4'd0);
    assign full     = (count == FIFO_DEPTH);
    assign head     = fifo_mem[rd_ptr];

    // Top bit padded so a 3-bit ID can index it without a range hole.
    assign complete_vec = {1'b0, complete_lpe, complete_comp_reshape,
                           complete_comp_ape, complete_comp_fc,
                           complete_comp_conv, complete_mov_gb2lb,
                           complete_mov_ddr2gb};

    // ------------------------------------------------------------------
    // Scheduler FSM: next state and per-cycle actions
    // ------------------------------------------------------------------
    logic         pop;
    logic         issue;
    logic         done_inc;
    logic         drain;
    logic         tmo_hit;

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        issue     = 1'b0;
        done_inc  = 1'b0;
        drain     = 1'b0;
        tmo_hit   = 1'b0;

        if (abort) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (run) begin
                        if (!empty) begin
                            state_nxt = ST_ISSUE;
                        end else begin
                            drain = 1'b1;
                        end
                    end
                end
                ST_ISSUE: begin
                    pop       = 1'b1;
                    issue     = 1'b1;
                    state_nxt = ST_WAIT;
                end
                ST_WAIT: begin
                    // Completion takes precedence over a coincident timeout.
                    if (complete_vec[cur_id]) begin
                        done_inc  = 1'b1;
                        state_nxt = empty ? ST_IDLE : ST_ISSUE;
                    end else if ((timeout_lim != 32'd0) &&
                                 (({1'b0, tmo_cnt} + 33'd1) >= {1'b0, timeout_lim})) begin
                        tmo_hit   = 1'b1;
                        state_nxt = ST_ERR;
                    end
                end
                ST_ERR: begin
                    state_nxt = ST_ERR;
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // A full FIFO still accepts a push when the head is leaving this cycle.
    assign push_ok = push_req && (!full || pop);
    assign ovf_set = push_req && full && !pop;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FIFO storage (contents need no reset; pointers/count do)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr] <= regif.regif_wdata[2:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_ptr <= 3'd0;
            wr_ptr <= 3'd0;
            count  <= 4'd0;
        end else if (abort) begin
            rd_ptr <= 3'd0;
            wr_ptr <= 3'd0;
            count  <= 4'd0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 3'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 3'd1;
            end
            count <= count + {3'b000, push_ok} - {3'b000, pop};
        end
    end

    // ------------------------------------------------------------------
    // Control and status registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            run         <= 1'b0;
            sticky_tmo  <= 1'b0;
            sticky_ovf  <= 1'b0;
            sticky_bad  <= 1'b0;
            irq         <= 1'b0;
            timeout_lim <= 32'd0;
            tmo_cnt     <= 32'd0;
            cur_id      <= 3'd0;
            done_cnt    <= 16'd0;
        end else begin
            // GO overrides the drain-time clear so a fresh GO is never lost.
            if (abort) begin
                run <= 1'b0;
            end else if (go) begin
                run <= 1'b1;
            end else if (drain) begin
                run <= 1'b0;
            end

            // New events win over a coincident CLR.
            sticky_tmo <= (sticky_tmo && !clr) || tmo_hit;
            sticky_ovf <= (sticky_ovf && !clr) || ovf_set;
            sticky_bad <= (sticky_bad && !clr) || bad_push;
            irq        <= (irq && !clr) || drain || tmo_hit;

            if (wr_timeout) begin
                timeout_lim <= regif.regif_wdata;
            end

            if (issue) begin
                tmo_cnt <= 32'd0;
                cur_id  <= head;
            end else if (state == ST_WAIT) begin
                tmo_cnt <= tmo_cnt + 32'd1;
            end

            if (done_inc) begin
                done_cnt <= done_cnt + 16'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Read path: one-cycle latency, sampled from pre-write state
    // ------------------------------------------------------------------
    logic [31:0]  status_word;
    logic [31:0]  read_mux;

    assign status_word = {done_cnt, 1'b0, cur_id, 1'b0, count, run,
                          sticky_bad, sticky_ovf, sticky_tmo,
                          empty, full, (state != ST_IDLE)};

    always_comb begin
        read_mux = 32'd0;
        case (regif.regif_addr)
            ADDR_STATUS:  read_mux = status_word;
            ADDR_TIMEOUT: read_mux = timeout_lim;
            default:      read_mux = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rvalid_q <= 1'b0;
            rdata_q  <= 32'd0;
        end else begin
            rvalid_q <= regif.regif_ren;
            rdata_q  <= regif.regif_ren ? read_mux : 32'd0;
        end
    end

    // ------------------------------------------------------------------
    // Outputs. Qualified with rst so nothing is visible while reset is
    // held, including the cycle in which it is first sampled.
    // ------------------------------------------------------------------
    logic [6:0]   start_vec;

    always_comb begin
        start_vec = 7'd0;
        for (int i = 0; i < 7; i++) begin
            start_vec[i] = issue && rst && (head == 3'(i));
        end
    end

    assign start_mov_ddr2gb   = start_vec[0];
    assign start_mov_gb2lb    = start_vec[1];
    assign start_comp_conv    = start_vec[2];
    assign start_comp_fc      = start_vec[3];
    assign start_comp_ape     = start_vec[4];
    assign start_comp_reshape = start_vec[5];
    assign start_lpe          = start_vec[6];

    assign sched_irq          = irq && rst;
    assign regif.regif_rvalid = rvalid_q && rst;
    assign regif.regif_rdata  = rst ? rdata_q : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_regif_task_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regif_task_scheduler
//  Description : Self-checking bench for regif_task_scheduler. A queue-based
//                reference model predicts start pulses, read data and the
//                interrupt every cycle; directed scenarios are followed by a
//                randomized phase.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_regif_task_scheduler;

    logic       clk;
    logic       rst;
    logic [6:0] complete;
    logic       s0, s1, s2, s3, s4, s5, s6;
    logic       sched_irq;

    regif_task_scheduler_if bus ();

    regif_task_scheduler dut (
        .clk                   (clk),
        .rst                   (rst),
        .regif                 (bus),
        .start_mov_ddr2gb      (s0),
        .start_mov_gb2lb       (s1),
        .start_comp_conv       (s2),
        .start_comp_fc         (s3),
        .start_comp_ape        (s4),
        .start_comp_reshape    (s5),
        .start_lpe             (s6),
        .complete_mov_ddr2gb   (complete[0]),
        .complete_mov_gb2lb    (complete[1]),
        .complete_comp_conv    (complete[2]),
        .complete_comp_fc      (complete[3]),
        .complete_comp_ape     (complete[4]),
        .complete_comp_reshape (complete[5]),
        .complete_lpe          (complete[6]),
        .sched_irq             (sched_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Reference model: mode 0 idle, 1 issuing, 2 waiting, 3 error
    int unsigned q[$];
    int          m_mode;
    bit          m_run, m_tmo, m_ovf, m_bad, m_irq;
    int unsigned m_cur;
    int unsigned m_done;
    logic [31:0] m_tlim;
    longint      m_waited;
    bit          m_rvalid;
    logic [31:0] m_rdata;

    logic [6:0]  last_start;
    logic [31:0] last_rdata;
    logic        last_rvalid;
    logic        last_irq;
    int          n_starts = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass = n_pass + 1;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_status();
        int unsigned n;
        n = q.size();
        return ((m_done & 32'hFFFF) << 16) | (m_cur << 12) | (n << 7) |
               (32'(m_run) << 6) | (32'(m_bad) << 5) | (32'(m_ovf) << 4) |
               (32'(m_tmo) << 3) | (32'(n == 0) << 2) | (32'(n == 8) << 1) |
               32'(m_mode != 0);
    endfunction

    function automatic logic [31:0] m_read(input logic [21:0] a);
        if (a == 22'h8) return m_status();
        if (a == 22'hC) return m_tlim;
        return 32'd0;
    endfunction

    function automatic bit in_abort();
        return bus.regif_wen && (bus.regif_addr == 22'h0) && bus.regif_wdata[1];
    endfunction

    task automatic model_update();
        bit wc, wq, wt, ab, go, cl;
        int unsigned pre_n, id;
        bit nv;
        logic [31:0] nd;
        if (!rst) begin
            q.delete();
            m_mode = 0; m_run = 0; m_tmo = 0; m_ovf = 0; m_bad = 0; m_irq = 0;
            m_cur = 0; m_done = 0; m_tlim = 0; m_waited = 0;
            m_rvalid = 0; m_rdata = 0;
            return;
        end
        wc = bus.regif_wen && bus.regif_addr == 22'h0;
        wq = bus.regif_wen && bus.regif_addr == 22'h4;
        wt = bus.regif_wen && bus.regif_addr == 22'hC;
        ab = wc && bus.regif_wdata[1];
        go = wc && bus.regif_wdata[0] && !bus.regif_wdata[1];
        cl = wc && bus.regif_wdata[2];
        nv = bus.regif_ren;
        nd = bus.regif_ren ? m_read(bus.regif_addr) : 32'd0;
        if (cl) begin m_tmo = 0; m_ovf = 0; m_bad = 0; m_irq = 0; end
        pre_n = q.size();
        if (ab) begin
            q.delete(); m_mode = 0; m_run = 0;
        end else begin
            case (m_mode)
                0: if (m_run) begin
                       if (pre_n > 0) m_mode = 1;
                       else begin m_run = 0; m_irq = 1; end
                   end
                1: begin m_cur = q.pop_front(); m_waited = 0; m_mode = 2; end
                2: begin
                       if (complete[m_cur]) begin
                           m_done = (m_done + 1) & 32'hFFFF;
                           m_mode = (pre_n > 0) ? 1 : 0;
                       end else if (m_tlim != 0 && m_waited + 1 >= longint'(m_tlim)) begin
                           m_mode = 3; m_tmo = 1; m_irq = 1;
                       end
                       m_waited++;
                   end
                default: ;
            endcase
        end
        if (go) m_run = 1;
        if (wq) begin
            id = bus.regif_wdata[2:0];
            if (id == 7) m_bad = 1;
            else if (q.size() < 8) q.push_back(id);
            else m_ovf = 1;
        end
        if (wt) m_tlim = bus.regif_wdata;
        m_rvalid = nv;
        m_rdata  = nd;
    endtask

    // One clock cycle: compare outputs with the model, advance the model,
    // then release the one-cycle strobes.
    task automatic tick();
        logic [6:0] obs, exp;
        @(negedge clk);
        obs = {s6, s5, s4, s3, s2, s1, s0};
        exp = '0;
        if (rst && m_mode == 1 && !in_abort()) exp[q[0]] = 1'b1;
        chk("start", {25'd0, obs}, {25'd0, exp});
        chk("rvalid", {31'd0, bus.regif_rvalid}, {31'd0, rst ? m_rvalid : 1'b0});
        chk("rdata", bus.regif_rdata, rst ? m_rdata : 32'd0);
        chk("irq", {31'd0, sched_irq}, {31'd0, rst ? m_irq : 1'b0});
        last_start  = obs;
        last_rdata  = bus.regif_rdata;
        last_rvalid = bus.regif_rvalid;
        last_irq    = sched_irq;
        n_starts += $countones(obs);
        model_update();
        @(posedge clk);
        #1;
        bus.regif_wen = 1'b0;
        bus.regif_ren = 1'b0;
        complete      = '0;
    endtask

    task automatic wr(input logic [21:0] a, input logic [31:0] d);
        bus.regif_addr  = a;
        bus.regif_wdata = d;
        bus.regif_wen   = 1'b1;
        tick();
    endtask

    task automatic rd(input logic [21:0] a, output logic [31:0] d);
        bus.regif_addr = a;
        bus.regif_ren  = 1'b1;
        tick();
        tick();
        d = last_rdata;
    endtask

    task automatic wait_start(output int id);
        bit found;
        found = 0;
        id = -1;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            if (last_start != 0) begin
                found = 1;
                for (int b = 0; b < 7; b++) if (last_start[b]) id = b;
            end
        end
        chk("start_seen", {31'd0, found}, 32'd1);
    endtask

    initial begin
        logic [31:0] d;
        int          id;
        int          base;
        int          exp_ids[3];
        int unsigned r;

        rst = 1'b0;
        complete = '0;
        bus.regif_addr = '0; bus.regif_wdata = '0;
        bus.regif_wen = 1'b0; bus.regif_ren = 1'b0;
        exp_ids[0] = 2; exp_ids[1] = 3; exp_ids[2] = 6;

        repeat (3) tick();
        rst = 1'b1;
        rd(22'h8, d);
        chk("reset_status", d, 32'h0000_0004);

        // Three tasks, each completed 5 cycles after its start
        wr(22'h4, 32'd2); wr(22'h4, 32'd3); wr(22'h4, 32'd6);
        wr(22'h0, 32'h1);
        for (int k = 0; k < 3; k++) begin
            wait_start(id);
            chk("order", id, exp_ids[k]);
            repeat (4) tick();
            if (id >= 0) complete[id] = 1'b1;
            tick();
        end
        repeat (2) tick();
        chk("drain_irq", {31'd0, last_irq}, 32'd1);
        rd(22'h8, d);
        chk("drain_status", d, 32'h0003_6004);

        // Illegal ID 7, then CLR
        wr(22'h4, 32'd7);
        rd(22'h8, d);
        chk("badcmd_status", d, 32'h0003_6024);
        wr(22'h0, 32'h4);
        rd(22'h8, d);
        chk("clr_status", d, 32'h0003_6004);
        chk("clr_irq", {31'd0, last_irq}, 32'd0);

        // Overflow: 9 pushes, only 8 retained and issued
        for (int i = 0; i < 9; i++) wr(22'h4, 32'(i % 7));
        rd(22'h8, d);
        chk("ovf_status", d, 32'h0003_6412);
        base = n_starts;
        wr(22'h0, 32'h1);
        for (int k = 0; k < 8; k++) begin
            wait_start(id);
            tick();
            if (id >= 0) complete[id] = 1'b1;
            tick();
        end
        repeat (5) tick();
        chk("ovf_starts", n_starts - base, 32'd8);
        wr(22'h0, 32'h4);

        // Foreign completion ignored while waiting on unit 2
        wr(22'h4, 32'd2);
        wr(22'h0, 32'h1);
        wait_start(id);
        tick();
        complete[3] = 1'b1;
        tick();
        rd(22'h8, d);
        chk("foreign_cmpl", d, 32'h000B_2045);
        complete[2] = 1'b1;
        tick();
        repeat (2) tick();
        rd(22'h8, d);
        chk("own_cmpl", d, 32'h000C_2004);
        wr(22'h0, 32'h4);

        // Timeout of 10 cycles
        wr(22'hC, 32'd10);
        rd(22'hC, d);
        chk("timeout_rb", d, 32'd10);
        wr(22'h4, 32'd0);
        wr(22'h0, 32'h1);
        wait_start(id);
        repeat (10) tick();
        chk("tmo_irq_early", {31'd0, last_irq}, 32'd0);
        tick();
        chk("tmo_irq", {31'd0, last_irq}, 32'd1);
        rd(22'h8, d);
        chk("err_status", d, 32'h000C_004D);
        wr(22'h0, 32'h2);
        rd(22'h8, d);
        chk("abort_status", d, 32'h000C_000C);
        wr(22'h0, 32'h4);
        wr(22'hC, 32'd0);

        // Unmapped read, then reset in the middle of a wait
        rd(22'h20, d);
        chk("unmapped_rdata", d, 32'd0);
        chk("unmapped_rvalid", {31'd0, last_rvalid}, 32'd1);
        wr(22'h4, 32'd1);
        wr(22'h0, 32'h1);
        wait_start(id);
        repeat (2) tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        base = n_starts;
        tick();
        chk("rst_start", {25'd0, last_start}, 32'd0);
        chk("rst_irq", {31'd0, last_irq}, 32'd0);
        chk("rst_rvalid", {31'd0, last_rvalid}, 32'd0);
        repeat (10) tick();
        chk("rst_no_start", n_starts - base, 32'd0);
        rd(22'h8, d);
        chk("rst_status", d, 32'h0000_0004);

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            r = $urandom_range(0, 99);
            rst = ($urandom_range(0, 399) != 0);
            if (r < 20) begin
                bus.regif_addr = 22'h4; bus.regif_wdata = 32'($urandom_range(0, 7));
                bus.regif_wen = 1'b1;
            end else if (r < 28) begin
                bus.regif_addr = 22'h0; bus.regif_wdata = 32'h1; bus.regif_wen = 1'b1;
            end else if (r < 29) begin
                bus.regif_addr = 22'h0; bus.regif_wdata = $urandom | 32'h2; bus.regif_wen = 1'b1;
            end else if (r < 32) begin
                bus.regif_addr = 22'h0; bus.regif_wdata = 32'h4; bus.regif_wen = 1'b1;
            end else if (r < 34) begin
                bus.regif_addr = 22'hC; bus.regif_wdata = 32'($urandom_range(0, 15));
                bus.regif_wen = 1'b1;
            end else if (r < 55) begin
                case ($urandom_range(0, 5))
                    0: bus.regif_addr = 22'h0;
                    1: bus.regif_addr = 22'h4;
                    2, 3: bus.regif_addr = 22'h8;
                    4: bus.regif_addr = 22'hC;
                    default: bus.regif_addr = 22'($urandom);
                endcase
                bus.regif_ren = 1'b1;
            end
            if (bus.regif_wen && $urandom_range(0, 3) == 0) bus.regif_ren = 1'b1;
            if (m_mode == 2 && $urandom_range(0, 3) == 0) complete[m_cur] = 1'b1;
            if ($urandom_range(0, 7) == 0) complete = complete | 7'($urandom);
            tick();
        end
        rst = 1'b1;
        repeat (2) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
